// File: rtl/substitute_pipe.sv
// AES byte-substitution pipeline stage: one headered block per handshake,
// LANES bytes per cycle through the forward or inverse S-box, result held until taken.
module substitute_pipe #(
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned LANES       = 4,
  parameter int unsigned HDR_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_inv,
  input  logic [HDR_W+8*BLOCK_BYTES-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [HDR_W+8*BLOCK_BYTES-1:0] out_data,
  output logic                          busy
);
  localparam int unsigned PAY_W  = 8 * BLOCK_BYTES;
  localparam int unsigned DATA_W = HDR_W + PAY_W;
  localparam int unsigned BEATS  = BLOCK_BYTES / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]                      r_state;
  logic [1:0]                      w_state_nxt;
  logic                            w_load;
  logic                            w_new_blk;
  logic [BEAT_W-1:0]               r_beat;
  logic [BEAT_W-1:0]               w_grp;
  logic                            w_last;
  logic [HDR_W-1:0]                r_hdr;
  logic                            r_inv;
  logic [BEATS-1:0][LANES-1:0][7:0] r_res;
  logic [BEATS-1:0][LANES-1:0][7:0] w_res_nxt;
  logic [LANES-1:0][7:0]           w_cur_grp;
  logic [LANES-1:0][7:0]           w_sub_grp;
  logic                            r_out_valid;
  logic [DATA_W-1:0]               r_out_data;
  logic                            r_busy;

  // Header 0 is a bubble: accepted but never starts a block.
  assign w_new_blk = in_valid && (in_data[DATA_W-1 -: HDR_W] != '0);
  assign w_last    = (r_beat == BEAT_W'(BEATS - 1));
  // Byte 0 is the MSB, so beat k works on the k-th group from the top.
  assign w_grp     = BEAT_W'(BEATS - 1) - r_beat;

  // Ready must follow out_ready in HOLD so a result can be swapped for a new block in one edge.
  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_new_blk) begin
          w_state_nxt = S_SUB;
          w_load      = 1'b1;
        end
      end
      S_SUB: begin
        if (w_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          if (w_new_blk) begin
            w_state_nxt = S_SUB;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    substitute_pipe_sbox u_sbox (
      .i_byte   (w_cur_grp[j]),
      .i_inv    (r_inv),
      .o_byte_c (w_sub_grp[j])
    );
  end

  always_comb begin
    w_cur_grp        = r_res[w_grp];
    w_res_nxt        = r_res;
    w_res_nxt[w_grp] = w_sub_grp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat      <= '0;
      r_hdr       <= '0;
      r_inv       <= 1'b0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (w_load) begin
        r_hdr  <= in_data[DATA_W-1 -: HDR_W];
        r_inv  <= in_inv;
        r_res  <= in_data[PAY_W-1:0];
        r_beat <= '0;
      end else if (r_state == S_SUB) begin
        r_res  <= w_res_nxt;
        r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
      end

      if ((r_state == S_SUB) && w_last) begin
        r_out_valid <= 1'b1;
        r_out_data  <= {r_hdr, w_res_nxt};
      end else if ((r_state == S_HOLD) && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end

      r_busy <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

// Combinational AES S-box lane holding both the forward and inverse tables.
module substitute_pipe_sbox (
  input  logic [7:0] i_byte,
  input  logic       i_inv,
  output logic [7:0] o_byte_c
);
  localparam logic [2047:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [2047:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] w_base;

  // Entry x sits (255 - x) bytes above the LSB, and 255 - x is simply ~x.
  assign w_base   = {~i_byte, 3'b000};
  assign o_byte_c = i_inv ? INV[w_base +: 8] : FWD[w_base +: 8];

endmodule

// File: tb/tb_substitute_pipe.sv
// Bench for substitute_pipe: directed and random blocks against an S-box model
// derived from GF(2^8) inversion plus the AES affine map.
module tb_substitute_pipe;
  localparam int unsigned PAY_W = 128;
  localparam int unsigned DW    = 132;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_inv, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, busy;
  logic [DW-1:0] out_data;
  logic          s1_valid, s1_in_ready, s1_out_valid, s1_busy;
  logic [DW-1:0] s1_out_data;
  logic          s16_valid, s16_in_ready, s16_out_valid, s16_busy;
  logic [DW-1:0] s16_out_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  substitute_pipe #(.BLOCK_BYTES(16), .LANES(4), .HDR_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy));

  substitute_pipe #(.BLOCK_BYTES(16), .LANES(1), .HDR_W(4)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(s1_valid), .in_ready(s1_in_ready), .in_inv(in_inv),
    .in_data(in_data), .out_valid(s1_out_valid), .out_ready(out_ready),
    .out_data(s1_out_data), .busy(s1_busy));

  substitute_pipe #(.BLOCK_BYTES(16), .LANES(16), .HDR_W(4)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(s16_valid), .in_ready(s16_in_ready), .in_inv(in_inv),
    .in_data(in_data), .out_valid(s16_out_valid), .out_ready(out_ready),
    .out_data(s16_out_data), .busy(s16_busy));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    for (int c = 1; c < 256; c++)
      if (x != 8'h00 && gmul(x, 8'(c)) == 8'h01) y = 8'(c);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [DW-1:0] model_block(input logic [3:0] hdr,
                                                input logic [PAY_W-1:0] pay, input logic inv);
    logic [PAY_W-1:0] r;
    logic [7:0]       v;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      v = pay[(15 - b) * 8 +: 8];
      r[(15 - b) * 8 +: 8] = inv ? inv_tab[v] : fwd_tab[v];
    end
    return {hdr, r};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks += 1;
    assert (got === exp) n_pass += 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits from just after acceptance until out_valid, checking latency and data.
  task automatic wait_result(input string tag, input logic [DW-1:0] exp, input int exp_lat);
    int lat;
    lat = 0;
    check({tag, "/busy"}, DW'(busy), DW'(1));
    check({tag, "/in_ready_sub"}, DW'(in_ready), DW'(0));
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "/latency"}, DW'(lat), DW'(exp_lat));
    check({tag, "/data"}, out_data, exp);
  endtask

  task automatic run_block(input string tag, input logic [3:0] hdr, input logic [PAY_W-1:0] pay,
                           input logic inv, input logic [DW-1:0] exp);
    check({tag, "/in_ready_idle"}, DW'(in_ready), DW'(1));
    in_valid = 1'b1;
    in_inv   = inv;
    in_data  = {hdr, pay};
    tick();
    in_valid = 1'b0;
    wait_result(tag, exp, 4);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "/valid_after_take"}, DW'(out_valid), DW'(0));
    check({tag, "/data_after_take"}, out_data, '0);
  endtask

  initial begin
    logic [PAY_W-1:0] pay, pay_b;
    logic [DW-1:0]    got, exp_a, exp_b;
    logic [3:0]       hdr;
    logic             inv;
    int               lat1, lat16;

    for (int x = 0; x < 256; x++) fwd_tab[x] = model_sbox(8'(x));
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
    s1_valid = 1'b0; s16_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset/out_valid", DW'(out_valid), DW'(0));
    check("reset/out_data", out_data, '0);
    check("reset/busy", DW'(busy), DW'(0));
    check("reset/in_ready", DW'(in_ready), DW'(1));

    // Known-answer vectors
    run_block("fwd_zero", 4'h5, '0, 1'b0, {4'h5, {16{8'h63}}});
    take("fwd_zero");
    run_block("byte_order", 4'hA, {4{32'h000153ff}}, 1'b0, {4'hA, {4{32'h637ced16}}});
    take("byte_order");
    run_block("inv_ed", 4'h3, {16{8'hed}}, 1'b1, {4'h3, {16{8'h53}}});
    take("inv_ed");

    // Random round trips and random blocks against the model
    for (int i = 0; i < 6; i++) begin
      hdr = 4'($urandom_range(15, 1));
      pay = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(1, 0));
      run_block("rand", hdr, pay, inv, model_block(hdr, pay, inv));
      got = out_data;
      take("rand");
      run_block("round_trip", hdr, got[PAY_W-1:0], ~inv, {hdr, pay});
      take("round_trip");
    end

    // Backpressure with a queued block, then a simultaneous swap, then a bubble
    pay   = {$urandom, $urandom, $urandom, $urandom};
    pay_b = {$urandom, $urandom, $urandom, $urandom};
    exp_a = model_block(4'h9, pay, 1'b0);
    exp_b = model_block(4'h6, pay_b, 1'b1);
    run_block("bp_a", 4'h9, pay, 1'b0, exp_a);
    in_valid = 1'b1; in_inv = 1'b1; in_data = {4'h6, pay_b};
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp/hold_valid", DW'(out_valid), DW'(1));
      check("bp/hold_data", out_data, exp_a);
      check("bp/hold_in_ready", DW'(in_ready), DW'(0));
    end
    out_ready = 1'b1;
    #1;
    check("bp/in_ready_follows", DW'(in_ready), DW'(1));
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp/swap_valid", DW'(out_valid), DW'(0));
    wait_result("bp_b", exp_b, 4);
    in_valid = 1'b1; in_data = {4'h0, pay};
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("bubble/busy", DW'(busy), DW'(0));
    check("bubble/in_ready", DW'(in_ready), DW'(1));
    for (int c = 0; c < 6; c++) begin
      tick();
      check("bubble/no_valid", DW'(out_valid), DW'(0));
    end
    in_valid = 1'b1; in_data = {4'h0, pay_b};
    tick();
    in_valid = 1'b0;
    check("bubble_idle/busy", DW'(busy), DW'(0));
    check("bubble_idle/in_ready", DW'(in_ready), DW'(1));

    // Asynchronous reset in the middle of a block
    in_valid = 1'b1; in_inv = 1'b0; in_data = {4'hC, pay};
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rst_mid/busy", DW'(busy), DW'(0));
    check("rst_mid/out_valid", DW'(out_valid), DW'(0));
    check("rst_mid/out_data", out_data, '0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rst_mid/discarded", DW'(out_valid), DW'(0));
    end
    run_block("after_rst", 4'h1, {16{8'h01}}, 1'b0, {4'h1, {16{8'h7c}}});
    take("after_rst");

    // Lane-count sweep
    s1_valid = 1'b1; s16_valid = 1'b1; in_inv = 1'b0; in_data = {4'h7, 128'h0};
    tick();
    s1_valid = 1'b0; s16_valid = 1'b0;
    lat1 = -1; lat16 = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (s16_out_valid && lat16 < 0) lat16 = c;
      if (s1_out_valid && lat1 < 0) lat1 = c;
      if (lat1 >= 0 && lat16 >= 0) break;
    end
    check("lanes1/latency", DW'(lat1), DW'(16));
    check("lanes16/latency", DW'(lat16), DW'(1));
    check("lanes1/data", s1_out_data, {4'h7, {16{8'h63}}});
    check("lanes16/data", s16_out_data, {4'h7, {16{8'h63}}});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("lanes1/idle", DW'({s1_busy, s1_in_ready, s1_out_valid}), DW'(3'b010));
    check("lanes16/idle", DW'({s16_busy, s16_in_ready, s16_out_valid}), DW'(3'b010));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
